// File: rtl/l2_write_buffer.sv
// rtl/l2_write_buffer.sv - L2 eviction write buffer with read-hit service and idle-time drain
module l2_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata,
  output logic         buf_empty,
  output logic         buf_full
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RESP, MEM_RD, DRAIN} state_t;

  state_t          state;
  logic [DEPTH-1:0] valid;
  logic [11:0]     tag  [DEPTH];
  logic [127:0]    data [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW:0]     count;
  logic            hit;
  logic [AW-1:0]   hit_idx;
  logic            unused_low_addr;

  assign unused_low_addr = ^mem_address[3:0];

  assign buf_empty = (count == '0);
  assign buf_full  = (count == (AW+1)'(DEPTH));

  // Writes coalesce, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tag[i] == mem_address[15:4]) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      valid        <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      mem_resp     <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      mem_rdata    <= '0;
    end else begin
      mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          // The request is still high during the mem_resp cycle; skip it once.
          if (!mem_resp) begin
            if (mem_read) begin
              if (hit) begin
                mem_rdata <= data[hit_idx];
                state     <= RESP;
              end else begin
                pmem_read    <= 1'b1;
                pmem_address <= {mem_address[15:4], 4'b0};
                state        <= MEM_RD;
              end
            end else if (mem_write && hit) begin
              data[hit_idx] <= mem_wdata;
              state         <= RESP;
            end else if (mem_write && !buf_full) begin
              valid[tail] <= 1'b1;
              tag[tail]   <= mem_address[15:4];
              data[tail]  <= mem_wdata;
              tail        <= tail + 1'b1;
              count       <= count + 1'b1;
              state       <= RESP;
            end else if (mem_write || !buf_empty) begin
              pmem_write   <= 1'b1;
              pmem_address <= {tag[head], 4'b0};
              pmem_wdata   <= data[head];
              state        <= DRAIN;
            end
          end
        end
        RESP: begin
          mem_resp <= 1'b1;
          state    <= IDLE;
        end
        MEM_RD: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            mem_rdata <= pmem_rdata;
            state     <= RESP;
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            pmem_write  <= 1'b0;
            valid[head] <= 1'b0;
            head        <= head + 1'b1;
            count       <= count - 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_write_buffer.sv
// tb/tb_l2_write_buffer.sv - directed self-checking bench for l2_write_buffer
module tb_l2_write_buffer;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [15:0]  mem_address = '0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp = 1'b0;
  logic [127:0] pmem_rdata = '0;
  logic         buf_empty;
  logic         buf_full;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int resp_cnt = 0;

  l2_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .buf_empty(buf_empty), .buf_full(buf_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (pmem_read)  rd_cnt   <= rd_cnt + 1;
    if (pmem_write) wr_cnt   <= wr_cnt + 1;
    if (mem_resp)   resp_cnt <= resp_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic req_start(input logic wr, input logic [15:0] addr, input logic [127:0] wd);
    mem_read    = !wr;
    mem_write   = wr;
    mem_address = addr;
    mem_wdata   = wd;
    t0          = cyc;
  endtask

  task automatic req_wait(output int lat, output logic [127:0] rd);
    int n = 0;
    @(negedge clk);
    while (!mem_resp && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!mem_resp) check("mem_resp_timeout", mem_resp, 1);
    lat = cyc - t0;
    rd  = mem_rdata;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic mem_serve(input logic [127:0] rd, output logic iw,
                           output logic [15:0] ad, output logic [127:0] wd);
    int n = 0;
    @(negedge clk);
    while (!(pmem_read || pmem_write) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(pmem_read || pmem_write)) check("pmem_strobe_timeout", pmem_read | pmem_write, 1);
    iw = pmem_write;
    ad = pmem_address;
    wd = pmem_wdata;
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
  endtask

  initial begin
    logic [127:0] da, db, dc, rd, wd;
    logic [127:0] dl [5];
    logic [15:0]  ad;
    logic         iw;
    int           lat, snap_rd, snap_wr, snap_resp, n;

    da = {4{32'hA5A5_0001}};
    db = {4{32'hB6B6_0002}};
    dc = {4{32'hC7C7_0003}};
    for (int i = 0; i < 5; i++) dl[i] = {4{32'h1000_0000 + 32'(i)}};

    // reset and idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    snap_rd = rd_cnt; snap_wr = wr_cnt; snap_resp = resp_cnt;
    repeat (10) @(negedge clk);
    check("idle_pmem_read", rd_cnt - snap_rd, 0);
    check("idle_pmem_write", wr_cnt - snap_wr, 0);
    check("idle_mem_resp", resp_cnt - snap_resp, 0);
    check("idle_buf_empty", buf_empty, 1);
    check("idle_buf_full", buf_full, 0);
    check("idle_pmem_address", pmem_address, 0);
    check("idle_mem_rdata", mem_rdata, 0);

    // single write then drain
    @(posedge clk); #1;
    req_start(1'b1, 16'h1230, da);
    req_wait(lat, rd);
    check("wr_latency", lat, 2);
    @(negedge clk);
    check("mem_resp_one_cycle", mem_resp, 0);
    mem_serve('0, iw, ad, wd);
    check("drain1_is_write", iw, 1);
    check("drain1_addr", ad, 16'h1230);
    check("drain1_data", wd, da);
    @(negedge clk);
    check("drain1_empty", buf_empty, 1);
    check("drain1_strobe_drop", pmem_write, 0);

    // read hit on buffered line
    snap_rd = rd_cnt;
    @(posedge clk); #1;
    req_start(1'b1, 16'h1230, da);
    req_wait(lat, rd);
    req_start(1'b0, 16'h1238, '0);
    req_wait(lat, rd);
    check("hit_latency", lat, 2);
    check("hit_rdata", rd, da);
    mem_serve('0, iw, ad, wd);
    check("hit_drain_addr", ad, 16'h1230);
    check("hit_no_pmem_read", rd_cnt - snap_rd, 0);

    // fill to full, stall a 5th write
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      req_start(1'b1, 16'((i + 1) * 16'h1000), dl[i]);
      req_wait(lat, rd);
      check("fill_latency", lat, 2);
    end
    snap_resp = resp_cnt;
    req_start(1'b1, 16'h5000, dl[4]);
    repeat (3) @(negedge clk);
    check("full_flag", buf_full, 1);
    check("full_stall_no_resp", resp_cnt - snap_resp, 0);
    check("full_drain_write", pmem_write, 1);
    mem_serve('0, iw, ad, wd);
    check("full_oldest_addr", ad, 16'h1000);
    check("full_oldest_data", wd, dl[0]);
    req_wait(lat, rd);
    @(negedge clk);
    check("full_after_accept", buf_full, 1);
    for (int i = 1; i < 5; i++) begin
      mem_serve('0, iw, ad, wd);
      check("full_order_addr", ad, 16'((i + 1) * 16'h1000));
      check("full_order_data", wd, dl[i]);
    end
    @(negedge clk);
    check("full_drained_empty", buf_empty, 1);

    // coalesced writes
    @(posedge clk); #1;
    req_start(1'b1, 16'h4000, da);
    req_wait(lat, rd);
    req_start(1'b1, 16'h4000, db);
    req_wait(lat, rd);
    check("coalesce_latency", lat, 2);
    snap_wr = wr_cnt;
    mem_serve('0, iw, ad, wd);
    check("coalesce_addr", ad, 16'h4000);
    check("coalesce_data", wd, db);
    @(negedge clk);
    check("coalesce_empty", buf_empty, 1);
    snap_wr = wr_cnt;
    repeat (5) @(negedge clk);
    check("coalesce_single_write", wr_cnt - snap_wr, 0);

    // read miss bypasses queued writes, then reset mid-drain
    @(posedge clk); #1;
    req_start(1'b1, 16'h1000, da);
    req_wait(lat, rd);
    req_start(1'b1, 16'h2000, db);
    req_wait(lat, rd);
    req_start(1'b0, 16'h8004, '0);
    mem_serve(dc, iw, ad, wd);
    check("miss_is_read", iw, 0);
    check("miss_addr", ad, 16'h8000);
    req_wait(lat, rd);
    check("miss_rdata", rd, dc);
    mem_serve('0, iw, ad, wd);
    check("miss_then_drain_addr", ad, 16'h1000);
    check("miss_then_drain_data", wd, da);
    n = 0;
    @(negedge clk);
    while (!pmem_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("second_drain_started", pmem_write, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_mem_resp", mem_resp, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_buf_empty", buf_empty, 1);
    check("rst_buf_full", buf_full, 0);
    pmem_resp = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    snap_rd = rd_cnt; snap_wr = wr_cnt;
    repeat (5) @(negedge clk);
    check("late_resp_ignored_wr", wr_cnt - snap_wr, 0);
    check("late_resp_ignored_rd", rd_cnt - snap_rd, 0);
    check("late_resp_empty", buf_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
